// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
package mem_arb_pkg;

  // Arbiter FSM states: idle, or the address/data phase of the granted side.
  typedef enum logic [2:0] {
    IDLE,
    I_ADDR,
    I_DATA,
    D_ADDR,
    D_DATA
  } arb_state_e;

  // Transfer size encodings on the data port and the shared bus.
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requests onto one single-outstanding SRAM-like bus.
// Data has priority; a starvation counter forces a fetch grant after STARVE_MAX
// consecutive data grants while a fetch waits. Completion is signalled by
// one-cycle *_data_ok pulses with registered read data.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch port
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_data_ok,
  // data memory port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_data_ok,
  // shared bus
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  // status
  output logic        busy
);

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  arb_state_e  state_q, state_d;
  logic [2:0]  starve_q, starve_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_wr_q, bus_wr_d;
  logic [1:0]  bus_size_q, bus_size_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic        inst_ok_q, inst_ok_d;
  logic        data_ok_q, data_ok_d;

  logic        inst_elig, data_elig;
  logic        grant_inst, grant_data;

  // A requester completing this cycle still holds its req; it must not be
  // re-granted until the following cycle.
  always_comb begin
    inst_elig  = inst_req && !inst_ok_q;
    data_elig  = data_req && !data_ok_q;
    grant_inst = inst_elig && (!data_elig || (starve_q == STARVE_LIM));
    grant_data = data_elig && !grant_inst;
  end

  // Next-state, payload latch, starvation counter and completion pulses.
  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    bus_req_d    = bus_req_q;
    bus_wr_d     = bus_wr_q;
    bus_size_d   = bus_size_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_ok_d    = 1'b0;
    data_ok_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!inst_req) begin
          starve_d = '0;
        end
        if (grant_inst) begin
          state_d     = I_ADDR;
          bus_req_d   = 1'b1;
          bus_wr_d    = 1'b0;
          bus_size_d  = SIZE_W;
          bus_addr_d  = inst_addr;
          bus_wdata_d = '0;
          starve_d    = '0;
        end else if (grant_data) begin
          state_d     = D_ADDR;
          bus_req_d   = 1'b1;
          bus_wr_d    = data_wr;
          bus_size_d  = data_size;
          bus_addr_d  = data_addr;
          bus_wdata_d = data_wdata;
          if (inst_req && (starve_q < STARVE_LIM)) begin
            starve_d = starve_q + 3'd1;
          end
        end
      end
      I_ADDR: begin
        if (bus_addr_ok) begin
          state_d   = I_DATA;
          bus_req_d = 1'b0;
        end
      end
      D_ADDR: begin
        if (bus_addr_ok) begin
          state_d   = D_DATA;
          bus_req_d = 1'b0;
        end
      end
      I_DATA: begin
        if (bus_data_ok) begin
          state_d      = IDLE;
          inst_rdata_d = bus_rdata;
          inst_ok_d    = 1'b1;
        end
      end
      D_DATA: begin
        if (bus_data_ok) begin
          state_d      = IDLE;
          data_rdata_d = bus_rdata;
          data_ok_d    = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      starve_q     <= '0;
      bus_req_q    <= 1'b0;
      bus_wr_q     <= 1'b0;
      bus_size_q   <= '0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_ok_q    <= 1'b0;
      data_ok_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      bus_req_q    <= bus_req_d;
      bus_wr_q     <= bus_wr_d;
      bus_size_q   <= bus_size_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_ok_q    <= inst_ok_d;
      data_ok_q    <= data_ok_d;
    end
  end

  assign inst_rdata   = inst_rdata_q;
  assign inst_data_ok = inst_ok_q;
  assign data_rdata   = data_rdata_q;
  assign data_data_ok = data_ok_q;
  assign bus_req      = bus_req_q;
  assign bus_wr       = bus_wr_q;
  assign bus_size     = bus_size_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wdata    = bus_wdata_q;
  assign busy         = (state_q != IDLE);

endmodule
